mtr_ovf_sched: RTL

Meter counter-overflow scheduler for the M8538 meter board. Collects carry-out events from the four hardware meter counters (TIME, PERF, EBOX, CACHE) and the interval-timer done condition, holds each as a pending service request, and raises a single meter interrupt to the PI system. Selects the highest-priority source and freezes it through the PI honor and microcode service handshake, so microcode can add the overflow into the memory-resident high-order counter word.

---
 rtl/mtr_ovf_sched.sv | 137 +++++++++++++
 1 files changed

// File: rtl/mtr_ovf_sched.sv
// mtr_ovf_sched -- meter counter-overflow scheduler.
// Collects carry-out events from the TIME/PERF/EBOX/CACHE meter counters and
// the interval-timer done level. Each event is held as a pending service
// request. The block raises one meter interrupt to PI and freezes the
// selected source across the PI honor / microcode service handshake.
//
// Optional feature: define MTR_OVF_LOST_EN to add the sticky LOST[3:0] port.
// LOST[i] records a carry that arrived while PENDING[i] was already set, so
// that carry merged into the existing request.

module mtr_ovf_sched (
    input  logic       clk,
    input  logic       RESET,
    input  logic [3:0] CARRY,
    input  logic       INTERVAL_DONE,
    input  logic [2:0] PIA,
    input  logic       HONOR,
    input  logic       HOLD_SEL,
    input  logic       SERVICE_DONE,
    output logic       INTERRUPT_REQ,
    output logic       VECTOR_REQ,
    output logic [1:0] INCR_SEL,
    output logic [3:0] PENDING,
`ifdef MTR_OVF_LOST_EN
    output logic [3:0] LOST,
`endif
    output logic       BUSY
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_GRANT = 2'd2
    } state_t;

    state_t     state;
    logic       any;
    logic       en;
    logic [1:0] win_sel;
    logic       win_vec;
    logic [3:0] clr;

    assign any = (|PENDING) | INTERVAL_DONE;
    assign en  = (PIA != 3'd0);

    // Fixed-priority winner: TIME, PERF, EBOX, CACHE, then the interval timer.
    always_comb begin
        // NOTE: every signal written in this block gets a default first.
        // A path that leaves a signal unassigned would infer a latch.
        win_sel = 2'd0;
        win_vec = 1'b0;
        if (PENDING[0])      win_sel = 2'd0;
        else if (PENDING[1]) win_sel = 2'd1;
        else if (PENDING[2]) win_sel = 2'd2;
        else if (PENDING[3]) win_sel = 2'd3;
        else if (INTERVAL_DONE) win_vec = 1'b1;
    end

    // Service completion clears the pending bit of the granted counter.
    // A vector (interval) grant clears nothing.
    always_comb begin
        clr = 4'b0000;
        if ((state == S_GRANT) && SERVICE_DONE && !VECTOR_REQ)
            clr[INCR_SEL] = 1'b1;
    end

    // Request/grant FSM with registered INTERRUPT_REQ and BUSY outputs.
    always_ff @(posedge clk or posedge RESET) begin
        // NOTE: sequential state uses non-blocking assignments only. Every
        // register here is small control state, so all of it takes the reset.
        if (RESET) begin
            state         <= S_IDLE;
            INTERRUPT_REQ <= 1'b0;
            BUSY          <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any && en) begin
                        state         <= S_REQ;
                        INTERRUPT_REQ <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (!en || !any) begin
                        state         <= S_IDLE;
                        INTERRUPT_REQ <= 1'b0;
                    end else if (HONOR) begin
                        state         <= S_GRANT;
                        INTERRUPT_REQ <= 1'b0;
                        BUSY          <= 1'b1;
                    end
                end
                S_GRANT: begin
                    if (SERVICE_DONE) begin
                        state <= S_IDLE;
                        BUSY  <= 1'b0;
                    end
                end
                default: begin
                    state         <= S_IDLE;
                    INTERRUPT_REQ <= 1'b0;
                    BUSY          <= 1'b0;
                end
            endcase
        end
    end

    // Selection tracks the live winner outside GRANT. The HONOR edge is the
    // last update, which latches the grant. HOLD_SEL freezes the selection so
    // the EBOX diagnostic read sees a stable value.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            INCR_SEL   <= 2'd0;
            VECTOR_REQ <= 1'b0;
        end else if (!HOLD_SEL && (state != S_GRANT)) begin
            INCR_SEL   <= win_sel;
            VECTOR_REQ <= win_vec;
        end
    end

    // Pending flags: a carry sets its bit and service clears it.
    // When both hit the same bit in one cycle, the carry wins.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) PENDING <= 4'b0000;
        else       PENDING <= (PENDING & ~clr) | CARRY;
    end

`ifdef MTR_OVF_LOST_EN
    // Sticky lost-overflow flags. A carry that lands on an already-pending
    // bit is lost unless the same cycle also clears that bit.
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) LOST <= 4'b0000;
        else       LOST <= LOST | (CARRY & PENDING & ~clr);
    end
`endif

endmodule
